// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/loader memory arbiter: FSM states and grant owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_LDR
    } gnt_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  gnt_t last,
    output logic valid,
    output gnt_t pick
);

    always_comb begin
        valid = req0 | req1;
        pick  = GNT_CPU;
        if (req0 && req1) begin
            pick = (last == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end else if (req1) begin
            pick = GNT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency byte memory between the multicycle CPU and the
// program loader, one access at a time with a one-cycle ack per access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             cpu_ack,
    input  logic             ldr_req,
    input  logic             ldr_we,
    input  logic [WIDTH-1:0] ldr_adr,
    input  logic [WIDTH-1:0] ldr_wd,
    output logic [WIDTH-1:0] ldr_rd,
    output logic             ldr_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_t           state, state_nxt;
    gnt_t             gnt, last_grant, arb_pick;
    logic             arb_valid, load;
    logic             g_we;
    logic [WIDTH-1:0] g_adr, g_wd, rd_q;
    logic [CW-1:0]    cnt;
    logic             mask_cpu, mask_ldr;

    // In DONE the acked port still holds req; hide it so only the other port can win.
    assign mask_cpu = (state == DONE) && (gnt == GNT_CPU);
    assign mask_ldr = (state == DONE) && (gnt == GNT_LDR);

    arb_rr2 u_arb (
        .req0  (cpu_req & ~mask_cpu),
        .req1  (ldr_req & ~mask_ldr),
        .last  (last_grant),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        ldr_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = g_we;
                state_nxt = g_we ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cpu_ack = (gnt == GNT_CPU);
                ldr_ack = (gnt == GNT_LDR);
                if (arb_valid) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant fields only change on the way into ISSUE, so they double as the
    // held memory address/data in every other state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= GNT_CPU;
            last_grant <= GNT_LDR;
            g_we       <= 1'b0;
            g_adr      <= '0;
            g_wd       <= '0;
            cnt        <= '0;
            rd_q       <= '0;
        end else begin
            state <= state_nxt;
            if (state == DONE) begin
                last_grant <= gnt;
            end
            if (load) begin
                gnt   <= arb_pick;
                g_we  <= (arb_pick == GNT_CPU) ? cpu_we  : ldr_we;
                g_adr <= (arb_pick == GNT_CPU) ? cpu_adr : ldr_adr;
                g_wd  <= (arb_pick == GNT_CPU) ? cpu_wd  : ldr_wd;
            end
            if (state == ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == WAIT && cnt == '0) begin
                rd_q <= mem_rd;
            end
        end
    end

    assign mem_adr = g_adr;
    assign mem_wd  = g_wd;
    assign cpu_rd  = rd_q;
    assign ldr_rd  = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// model of the arbitration, latency and memory-content rules.
module tb_mem_arbiter;

    localparam int LAT = 3;

    localparam int M_SCRIPT = 0;
    localparam int M_RAND   = 1;
    localparam int M_CONT   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_v [2];
    logic       we_v  [2];
    logic [7:0] adr_v [2];
    logic [7:0] wd_v  [2];
    logic [7:0] cpu_rd, ldr_rd, mem_adr, mem_wd, mem_rd;
    logic       cpu_ack, ldr_ack, mem_en, mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(8), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (req_v[0]),
        .cpu_we  (we_v[0]),
        .cpu_adr (adr_v[0]),
        .cpu_wd  (wd_v[0]),
        .cpu_rd  (cpu_rd),
        .cpu_ack (cpu_ack),
        .ldr_req (req_v[1]),
        .ldr_we  (we_v[1]),
        .ldr_adr (adr_v[1]),
        .ldr_wd  (wd_v[1]),
        .ldr_rd  (ldr_rd),
        .ldr_ack (ldr_ack),
        .mem_en  (mem_en),
        .mem_we  (mem_we),
        .mem_adr (mem_adr),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    function automatic logic [7:0] initByte(input logic [7:0] a);
        return a ^ 8'hB5;
    endfunction

    // Memory with LAT-cycle read pipeline; unwritten locations read as initByte.
    bit [7:0] phys_mem [256];
    bit       phys_wr  [256];
    bit [7:0] pipe     [LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            phys_mem[mem_adr] <= mem_wd;
            phys_wr[mem_adr]  <= 1'b1;
        end
        pipe[0] <= phys_wr[mem_adr] ? phys_mem[mem_adr] : initByte(mem_adr);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rd = pipe[LAT-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = M_SCRIPT;

    // Reference model state.
    bit       m_busy;
    int       m_own, m_lastg, m_issue, m_ack;
    bit       m_we;
    bit [7:0] m_adr, m_wd, hold_adr, hold_wd, exp_rd;
    bit       rd_zero_chk = 1'b1;
    bit [7:0] ref_mem [256];
    bit       ref_wr  [256];

    bit       ack_seen [2];
    bit       prev_pend [2];
    bit       prev_we [2];
    bit [7:0] prev_adr [2], prev_wd [2];
    int       ack_log[$];
    int       ack_cyc_log[$];
    int       last_ack_cyc [2];
    bit [7:0] last_ack_rd [2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_busy   = 1'b0;
        m_lastg  = 1;
        hold_adr = 8'h00;
        hold_wd  = 8'h00;
        exp_rd   = 8'h00;
    endtask

    task automatic grant(input int p);
        m_own   = p;
        m_busy  = 1'b1;
        m_we    = we_v[p];
        m_adr   = adr_v[p];
        m_wd    = wd_v[p];
        m_issue = cyc + 1;
        m_ack   = cyc + 2 + (m_we ? 0 : LAT);
    endtask

    task automatic checkCycle();
        bit e_en;
        bit e_ack [2];
        bit done_now;
        e_en = m_busy && (cyc == m_issue);
        if (e_en) begin
            hold_adr = m_adr;
            hold_wd  = m_wd;
        end
        done_now = m_busy && (cyc == m_ack);
        e_ack[0] = done_now && (m_own == 0);
        e_ack[1] = done_now && (m_own == 1);
        checkOutput("mem_en",  32'(mem_en),  32'(e_en));
        checkOutput("mem_we",  32'(mem_we),  32'(e_en && m_we));
        checkOutput("mem_adr", 32'(mem_adr), 32'(hold_adr));
        checkOutput("mem_wd",  32'(mem_wd),  32'(hold_wd));
        checkOutput("cpu_ack", 32'(cpu_ack), 32'(e_ack[0]));
        checkOutput("ldr_ack", 32'(ldr_ack), 32'(e_ack[1]));
        ack_seen[0] = cpu_ack;
        ack_seen[1] = ldr_ack;
        if (rd_zero_chk) begin
            checkOutput("cpu_rd_reset", 32'(cpu_rd), 32'(0));
            checkOutput("ldr_rd_reset", 32'(ldr_rd), 32'(0));
            rd_zero_chk = 1'b0;
        end
        if (done_now) begin
            if (!m_we) begin
                exp_rd = ref_wr[m_adr] ? ref_mem[m_adr] : initByte(m_adr);
            end else begin
                ref_mem[m_adr] = m_wd;
                ref_wr[m_adr]  = 1'b1;
            end
            if (m_own == 0) checkOutput("cpu_rd", 32'(cpu_rd), 32'(exp_rd));
            else            checkOutput("ldr_rd", 32'(ldr_rd), 32'(exp_rd));
        end
        for (int p = 0; p < 2; p++) begin
            if (ack_seen[p]) begin
                ack_log.push_back(p);
                ack_cyc_log.push_back(cyc);
                last_ack_cyc[p] = cyc;
                last_ack_rd[p]  = (p == 0) ? cpu_rd : ldr_rd;
            end
            if (prev_pend[p]) begin
                assert (req_v[p] && we_v[p] == prev_we[p] && adr_v[p] == prev_adr[p] && wd_v[p] == prev_wd[p])
                    else $error("[TB] illegal stimulus on port %0d", p);
            end
            prev_pend[p] = req_v[p] && !ack_seen[p];
            prev_we[p]   = we_v[p];
            prev_adr[p]  = adr_v[p];
            prev_wd[p]   = wd_v[p];
        end
        if (!reset) begin
            modelReset();
            rd_zero_chk = 1'b1;
        end else if (done_now) begin
            m_lastg = m_own;
            m_busy  = 1'b0;
            if (req_v[1 - m_own]) grant(1 - m_own);
        end else if (!m_busy) begin
            if (req_v[0] && req_v[1]) grant((m_lastg == 0) ? 1 : 0);
            else if (req_v[0])        grant(0);
            else if (req_v[1])        grant(1);
        end
    endtask

    task automatic issueReq(input int p, input bit we, input logic [7:0] adr, input logic [7:0] wd);
        req_v[p] = 1'b1;
        we_v[p]  = we;
        adr_v[p] = adr;
        wd_v[p]  = wd;
    endtask

    task automatic newReq(input int p);
        issueReq(p, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 8'($urandom));
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < 2; p++) begin
            if (req_v[p] && !ack_seen[p]) begin
                // access still pending: hold everything
            end else if (mode == M_CONT) begin
                newReq(p);
            end else if (mode == M_RAND) begin
                if (req_v[p]) begin
                    if ($urandom_range(1, 0) == 1) newReq(p);
                    else req_v[p] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    newReq(p);
                end
            end else if (req_v[p]) begin
                req_v[p] = 1'b0;
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            checkCycle();
            @(posedge clk);
            cyc++;
            #1;
            applyStimulus();
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((req_v[0] || req_v[1]) && n < budget) begin
            runCycles(1);
            n++;
        end
        if (req_v[0] || req_v[1]) checkOutput("wait_budget", {30'd0, req_v[1], req_v[0]}, 32'd0);
    endtask

    initial begin
        int c0, s;
        logic [7:0] a8;
        modelReset();
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; adr_v[p] = 8'h00; wd_v[p] = 8'h00;
        end
        @(posedge clk);
        cyc++;
        #1;
        runCycles(3);
        reset = 1'b1;
        runCycles(2);

        $display("[TB] single CPU read");
        c0 = cyc;
        issueReq(0, 1'b0, 8'h10, 8'h00);
        waitIdle(60);
        checkOutput("t1_latency", 32'(last_ack_cyc[0] - c0), 32'(2 + LAT));
        checkOutput("t1_rd", 32'(last_ack_rd[0]), 32'h A5);
        runCycles(2);

        $display("[TB] loader write then CPU read");
        c0 = cyc;
        issueReq(1, 1'b1, 8'h20, 8'h3C);
        waitIdle(60);
        checkOutput("t2_wr_latency", 32'(last_ack_cyc[1] - c0), 32'd2);
        runCycles(3);
        c0 = cyc;
        issueReq(0, 1'b0, 8'h20, 8'h00);
        waitIdle(60);
        checkOutput("t2_rd_latency", 32'(last_ack_cyc[0] - c0), 32'(2 + LAT));
        checkOutput("t2_rd", 32'(last_ack_rd[0]), 32'h3C);

        $display("[TB] instruction fetch");
        for (int i = 0; i < 4; i++) begin
            a8 = 8'(i);
            c0 = last_ack_cyc[0];
            issueReq(0, 1'b0, a8, 8'h00);
            waitIdle(60);
            checkOutput("fetch_rd", 32'(last_ack_rd[0]), 32'(initByte(a8)));
            checkOutput("fetch_gap", 32'(last_ack_cyc[0] - c0 > 1), 32'd1);
        end

        $display("[TB] simultaneous requests from reset");
        reset = 1'b0;
        runCycles(2);
        reset = 1'b1;
        s = ack_log.size();
        issueReq(0, 1'b0, 8'h30, 8'h00);
        issueReq(1, 1'b0, 8'h31, 8'h00);
        waitIdle(80);
        checkOutput("t3_count", 32'(ack_log.size() - s), 32'd2);
        if (ack_log.size() >= s + 2) begin
            checkOutput("t3_first",  32'(ack_log[s]),     32'd0);
            checkOutput("t3_second", 32'(ack_log[s + 1]), 32'd1);
            checkOutput("t3_no_bubble", 32'(ack_cyc_log[s + 1] - ack_cyc_log[s]), 32'(2 + LAT));
        end

        $display("[TB] sustained contention");
        mode = M_CONT;
        s = ack_log.size();
        for (int n = 0; n < 400 && ack_log.size() < s + 8; n++) runCycles(1);
        mode = M_SCRIPT;
        checkOutput("t5_count", 32'(ack_log.size() >= s + 8), 32'd1);
        if (ack_log.size() >= s + 8) begin
            c0 = 0;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) checkOutput("t5_alternate", 32'(ack_log[s + k]), 32'(1 - ack_log[s + k - 1]));
                if (ack_log[s + k] == 0) c0++;
            end
            checkOutput("t5_cpu_share", 32'(c0), 32'd4);
        end
        waitIdle(100);
        runCycles(2);

        $display("[TB] reset during read wait");
        s = ack_log.size();
        issueReq(0, 1'b0, 8'h11, 8'h00);
        runCycles(3);
        reset = 1'b0;
        runCycles(1);
        reset = 1'b1;
        waitIdle(60);
        checkOutput("t6_ack_count", 32'(ack_log.size() - s), 32'd1);
        checkOutput("t6_rd", 32'(last_ack_rd[0]), 32'(initByte(8'h11)));

        $display("[TB] random traffic");
        mode = M_RAND;
        runCycles(1500);
        mode = M_SCRIPT;
        waitIdle(200);
        runCycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
